// File: rtl/noc_pkg.sv
// Shared definitions for the 5-port mesh router: port numbering, lock states and
// the flit width.
package noc_pkg;

  localparam int NPORTS = 5;
  localparam int PIDX_W = 3;
  localparam int FLIT_W = 16;

  typedef enum logic [2:0] {
    P_N = 3'd0,
    P_S = 3'd1,
    P_E = 3'd2,
    P_W = 3'd3,
    P_L = 3'd4
  } port_e;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_BUSY = 1'b1
  } lock_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after the
// pointer, wrapping from NPORTS-1 back to 0. Output is one-hot or zero.
module rr_arbiter #(
  parameter int NPORTS = noc_pkg::NPORTS,
  parameter int PIDX_W = noc_pkg::PIDX_W
) (
  input  logic [NPORTS-1:0] i_req,
  input  logic [PIDX_W-1:0] i_ptr,
  output logic [NPORTS-1:0] o_gnt
);

  int   w_idx;
  logic w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NPORTS; k++) begin
      w_idx = (int'(i_ptr) + k) % NPORTS;
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output packet lock with round-robin arbitration
// between packets, zero-cycle grant/select from registered lock state.
module switch_allocator
  import noc_pkg::lock_e, noc_pkg::LOCK_IDLE, noc_pkg::LOCK_BUSY;
#(
  parameter int NPORTS = noc_pkg::NPORTS,
  parameter int PIDX_W = noc_pkg::PIDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        req_i,
  input  logic [NPORTS*PIDX_W-1:0] dest_i,
  input  logic [NPORTS-1:0]        tail_i,
  input  logic [NPORTS-1:0]        out_rdy_i,
  output logic [NPORTS-1:0]        gnt_o,
  output logic [NPORTS-1:0]        out_vld_o,
  output logic [NPORTS*PIDX_W-1:0] sel_o,
  output logic                     err_o
);

  localparam logic [PIDX_W-1:0] NP_L   = PIDX_W'(NPORTS);
  localparam logic [PIDX_W-1:0] LAST_L = PIDX_W'(NPORTS - 1);

  lock_e             r_state    [NPORTS];
  lock_e             w_state_nx [NPORTS];
  logic [PIDX_W-1:0] r_owner    [NPORTS];
  logic [PIDX_W-1:0] w_owner_nx [NPORTS];
  logic [PIDX_W-1:0] r_ptr      [NPORTS];
  logic [PIDX_W-1:0] w_ptr_nx   [NPORTS];
  logic              r_err;

  logic [PIDX_W-1:0] w_dest     [NPORTS];
  logic [NPORTS-1:0] w_legal;
  logic [NPORTS-1:0] w_illegal;
  logic [NPORTS-1:0] w_owns;
  logic [NPORTS-1:0] w_cand     [NPORTS];
  logic [NPORTS-1:0] w_arb_gnt  [NPORTS];
  logic [PIDX_W-1:0] w_win      [NPORTS];
  logic [PIDX_W-1:0] w_sel      [NPORTS];
  logic [NPORTS-1:0] w_gnt;
  logic [NPORTS-1:0] w_out_vld;
  logic [NPORTS-1:0] w_proto_err;

  function automatic logic [PIDX_W-1:0] f_next_ptr(input logic [PIDX_W-1:0] idx);
    return (idx == LAST_L) ? '0 : idx + 1'b1;
  endfunction

  // An input that holds a lock is excluded from new arbitration elsewhere, so a
  // mid-packet destination change can never steal a second output.
  always_comb begin
    w_legal   = '0;
    w_illegal = '0;
    w_owns    = '0;
    for (int i = 0; i < NPORTS; i++) begin
      w_dest[i]    = dest_i[PIDX_W*i +: PIDX_W];
      w_legal[i]   = req_i[i] && (w_dest[i] < NP_L) && (w_dest[i] != PIDX_W'(i));
      w_illegal[i] = req_i[i] && !w_legal[i];
      for (int o = 0; o < NPORTS; o++) begin
        if (r_state[o] == LOCK_BUSY && r_owner[o] == PIDX_W'(i)) w_owns[i] = 1'b1;
      end
    end
    for (int o = 0; o < NPORTS; o++) begin
      w_cand[o] = '0;
      for (int i = 0; i < NPORTS; i++) begin
        w_cand[o][i] = w_legal[i] && (w_dest[i] == PIDX_W'(o)) && !w_owns[i];
      end
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_arb
    rr_arbiter #(
      .NPORTS (NPORTS),
      .PIDX_W (PIDX_W)
    ) u_arb (
      .i_req (w_cand[g]),
      .i_ptr (r_ptr[g]),
      .o_gnt (w_arb_gnt[g])
    );
  end

  always_comb begin
    w_gnt       = '0;
    w_out_vld   = '0;
    w_proto_err = '0;
    for (int o = 0; o < NPORTS; o++) begin
      w_state_nx[o] = r_state[o];
      w_owner_nx[o] = r_owner[o];
      w_ptr_nx[o]   = r_ptr[o];
      w_sel[o]      = '0;
      w_win[o]      = '0;
      for (int i = 0; i < NPORTS; i++) begin
        if (w_arb_gnt[o][i]) w_win[o] = PIDX_W'(i);
      end
      case (r_state[o])
        LOCK_IDLE: begin
          if (out_rdy_i[o] && (|w_arb_gnt[o])) begin
            w_out_vld[o]    = 1'b1;
            w_sel[o]        = w_win[o];
            w_gnt[w_win[o]] = 1'b1;
            if (tail_i[w_win[o]]) begin
              w_ptr_nx[o] = f_next_ptr(w_win[o]);
            end else begin
              w_state_nx[o] = LOCK_BUSY;
              w_owner_nx[o] = w_win[o];
            end
          end
        end
        LOCK_BUSY: begin
          if (req_i[r_owner[o]]) begin
            if (w_dest[r_owner[o]] != PIDX_W'(o)) begin
              w_proto_err[o] = 1'b1;
            end else if (out_rdy_i[o]) begin
              w_out_vld[o]       = 1'b1;
              w_sel[o]           = r_owner[o];
              w_gnt[r_owner[o]]  = 1'b1;
              if (tail_i[r_owner[o]]) begin
                w_state_nx[o] = LOCK_IDLE;
                w_ptr_nx[o]   = f_next_ptr(r_owner[o]);
              end
            end
          end
        end
        default: w_state_nx[o] = LOCK_IDLE;
      endcase
    end
  end

  always_comb begin
    gnt_o     = rst ? w_gnt : '0;
    out_vld_o = rst ? w_out_vld : '0;
    sel_o     = '0;
    for (int o = 0; o < NPORTS; o++) begin
      sel_o[PIDX_W*o +: PIDX_W] = rst ? w_sel[o] : '0;
    end
  end

  assign err_o = r_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int o = 0; o < NPORTS; o++) begin
        r_state[o] <= LOCK_IDLE;
        r_owner[o] <= '0;
        r_ptr[o]   <= '0;
      end
      r_err <= 1'b0;
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        r_state[o] <= w_state_nx[o];
        r_owner[o] <= w_owner_nx[o];
        r_ptr[o]   <= w_ptr_nx[o];
      end
      r_err <= r_err | (|w_illegal) | (|w_proto_err);
    end
  end

endmodule
